clock_mode_controller: RTL and testbench

Sequencer for the core clock multiplier (PLL stand-in). It accepts a slow/fast mode request and halts the core at a safe point. It then drives `multiply`, waits for lock, and only after that switches the core clock select. On the way back down it unswitches before releasing `multiply`. It runs entirely in the `base_clock` domain and sits between the core's halt logic and the clock multiplier / clock select mux.

---
 rtl/clock_mode_controller_pkg.sv | 40 ++++
 rtl/clock_mode_controller_cycle_counter.sv | 33 +++
 rtl/clock_mode_controller.sv | 127 ++++++++++++
 tb/tb_clock_mode_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/clock_mode_controller_pkg.sv
// Shared definitions for the clock mode sequencer: state encoding, default
// timing parameters and the Moore output decode.
package clock_mode_controller_pkg;

    typedef enum logic [2:0] {
        ST_SLOW       = 3'd0,
        ST_QUIESCE_UP = 3'd1,
        ST_LOCK_WAIT  = 3'd2,
        ST_FAST       = 3'd3,
        ST_QUIESCE_DN = 3'd4,
        ST_RELEASE    = 3'd5
    } state_e;

    localparam int DEF_LOCK_CYCLES = 64;
    localparam int DEF_SWITCH_GAP  = 4;

    typedef struct packed {
        logic halt;
        logic mult;
        logic sel;
        logic fast;
        logic busy;
    } ctrl_t;

    // Unused encodings decode to the safe SLOW pattern.
    function automatic ctrl_t decode_state(input state_e s);
        ctrl_t c;
        case (s)
            ST_SLOW:       c = '{halt: 1'b0, mult: 1'b0, sel: 1'b0, fast: 1'b0, busy: 1'b0};
            ST_QUIESCE_UP: c = '{halt: 1'b1, mult: 1'b0, sel: 1'b0, fast: 1'b0, busy: 1'b1};
            ST_LOCK_WAIT:  c = '{halt: 1'b1, mult: 1'b1, sel: 1'b0, fast: 1'b0, busy: 1'b1};
            ST_FAST:       c = '{halt: 1'b0, mult: 1'b1, sel: 1'b1, fast: 1'b1, busy: 1'b0};
            ST_QUIESCE_DN: c = '{halt: 1'b1, mult: 1'b1, sel: 1'b1, fast: 1'b0, busy: 1'b1};
            ST_RELEASE:    c = '{halt: 1'b1, mult: 1'b1, sel: 1'b0, fast: 1'b0, busy: 1'b1};
            default:       c = '{halt: 1'b0, mult: 1'b0, sel: 1'b0, fast: 1'b0, busy: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/clock_mode_controller_cycle_counter.sv
// Up-counter with synchronous clear/enable and a compare against a runtime
// limit; shared between the lock wait and the release gap.
module cycle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count    = cnt_r;
    assign terminal = (cnt_r == limit);

endmodule

// File: rtl/clock_mode_controller.sv
// Clock mode sequencer: halts the core, brings the multiplier up to lock,
// then switches the core clock; reverses the order on the way down.
import clock_mode_controller_pkg::*;

module clock_mode_controller #(
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int SWITCH_GAP  = DEF_SWITCH_GAP,
    parameter int CNT_W       = 8
) (
    input  logic base_clock,
    input  logic reset_n,
    input  logic mode_req,
    input  logic core_idle,
    input  logic pll_lock,
    output logic core_halt,
    output logic multiply,
    output logic clk_sel,
    output logic mode_fast,
    output logic busy,
    output logic lock_fault
);

    state_e           state_r;
    state_e           next_state_s;
    ctrl_t            ctrl_r;
    logic             fault_r;
    logic             fault_set_s;
    logic             fault_clr_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             terminal_s;
    logic [CNT_W-1:0] limit_s;
    logic [CNT_W-1:0] count_s;

    cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (base_clock),
        .reset_n  (reset_n),
        .clr      (cnt_clr_s),
        .en       (cnt_en_s),
        .limit    (limit_s),
        .count    (count_s),
        .terminal (terminal_s)
    );

    // Next-state, lock fault set/clear and counter control.
    always_comb begin
        next_state_s = state_r;
        fault_set_s  = 1'b0;
        case (state_r)
            ST_SLOW: begin
                if (mode_req && !fault_r) next_state_s = ST_QUIESCE_UP;
                else                      next_state_s = ST_SLOW;
            end
            ST_QUIESCE_UP: begin
                if (core_idle)     next_state_s = ST_LOCK_WAIT;
                else if (!mode_req) next_state_s = ST_SLOW;
                else               next_state_s = ST_QUIESCE_UP;
            end
            ST_LOCK_WAIT: begin
                if (terminal_s) begin
                    if (pll_lock) begin
                        next_state_s = ST_FAST;
                    end else begin
                        next_state_s = ST_RELEASE;
                        fault_set_s  = 1'b1;
                    end
                end else begin
                    next_state_s = ST_LOCK_WAIT;
                end
            end
            ST_FAST: begin
                if (!pll_lock) begin
                    next_state_s = ST_QUIESCE_DN;
                    fault_set_s  = 1'b1;
                end else if (!mode_req) begin
                    next_state_s = ST_QUIESCE_DN;
                end else begin
                    next_state_s = ST_FAST;
                end
            end
            ST_QUIESCE_DN: begin
                if (core_idle) next_state_s = ST_RELEASE;
                else           next_state_s = ST_QUIESCE_DN;
            end
            ST_RELEASE: begin
                if (terminal_s) next_state_s = ST_SLOW;
                else            next_state_s = ST_RELEASE;
            end
            default: next_state_s = ST_SLOW;
        endcase
    end

    assign fault_clr_s = (state_r == ST_SLOW) && !mode_req;
    assign cnt_en_s    = (state_r == ST_LOCK_WAIT) || (state_r == ST_RELEASE);
    // Every state change restarts the count so each counted phase begins at 0.
    assign cnt_clr_s   = (next_state_s != state_r);
    assign limit_s     = (state_r == ST_RELEASE) ? CNT_W'(SWITCH_GAP - 1)
                                                 : CNT_W'(LOCK_CYCLES - 1);

    // State register.
    always_ff @(posedge base_clock) begin
        if (!reset_n) state_r <= ST_SLOW;
        else          state_r <= next_state_s;
    end

    // Outputs registered from the next-state decode so they track state_r exactly.
    always_ff @(posedge base_clock) begin
        if (!reset_n) ctrl_r <= decode_state(ST_SLOW);
        else          ctrl_r <= decode_state(next_state_s);
    end

    // Sticky lock fault; only a deasserted request in SLOW clears it.
    always_ff @(posedge base_clock) begin
        if (!reset_n)         fault_r <= 1'b0;
        else if (fault_set_s) fault_r <= 1'b1;
        else if (fault_clr_s) fault_r <= 1'b0;
        else                  fault_r <= fault_r;
    end

    assign core_halt  = ctrl_r.halt;
    assign multiply   = ctrl_r.mult;
    assign clk_sel    = ctrl_r.sel;
    assign mode_fast  = ctrl_r.fast;
    assign busy       = ctrl_r.busy;
    assign lock_fault = fault_r;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with LOCK_CYCLES=64, SWITCH_GAP=4.
// Output vector order: {core_halt, multiply, clk_sel, mode_fast, busy, lock_fault}.
module tb_clock_mode_controller;

    logic base_clock = 1'b0;
    logic reset_n    = 1'b0;
    logic mode_req   = 1'b0;
    logic core_idle  = 1'b0;
    logic pll_lock   = 1'b0;
    logic core_halt, multiply, clk_sel, mode_fast, busy, lock_fault;

    int vectors     = 0;
    int miscompares = 0;

    clock_mode_controller #(.LOCK_CYCLES(64), .SWITCH_GAP(4), .CNT_W(8)) dut (
        .base_clock (base_clock),
        .reset_n    (reset_n),
        .mode_req   (mode_req),
        .core_idle  (core_idle),
        .pll_lock   (pll_lock),
        .core_halt  (core_halt),
        .multiply   (multiply),
        .clk_sel    (clk_sel),
        .mode_fast  (mode_fast),
        .busy       (busy),
        .lock_fault (lock_fault)
    );

    always #5 base_clock = ~base_clock;

    localparam logic [5:0] O_SLOW  = 6'b000000;
    localparam logic [5:0] O_QUP   = 6'b100010;
    localparam logic [5:0] O_LW    = 6'b110010;
    localparam logic [5:0] O_FAST  = 6'b011100;
    localparam logic [5:0] O_QDN   = 6'b111010;
    localparam logic [5:0] O_REL   = 6'b110010;
    localparam logic [5:0] F       = 6'b000001;

    task automatic step();
        @(posedge base_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {core_halt, multiply, clk_sel, mode_fast, busy, lock_fault};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        step();
        step();
        chk("reset", O_SLOW);
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", O_SLOW);

        // Basic up transition
        core_idle = 1'b1;
        pll_lock  = 1'b1;
        mode_req  = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            step();
            if (e == 1)  chk("up_e1_quiesce", O_QUP);
            if (e == 2)  chk("up_e2_mult", O_LW);
            if (e == 65) chk("up_e65_still_lw", O_LW);
            if (e == 66) chk("up_e66_fast", O_FAST);
        end

        // Round trip down with core_idle delayed
        core_idle = 1'b0;
        mode_req  = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 1)  chk("dn_e1_quiesce", O_QDN);
            if (e == 6)  begin chk("dn_e6_wait_idle", O_QDN); core_idle = 1'b1; end
            if (e == 7)  chk("dn_e7_sel_drop", O_REL);
            if (e == 10) chk("dn_e10_gap", O_REL);
            if (e == 11) chk("dn_e11_slow", O_SLOW);
        end

        // Lock timeout
        pll_lock = 1'b0;
        mode_req = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            step();
            if (e == 2)  chk("to_e2_lw", O_LW);
            if (e == 65) chk("to_e65_lw", O_LW);
            if (e == 66) chk("to_e66_release", O_REL | F);
            if (e == 69) chk("to_e69_release", O_REL | F);
            if (e == 70) chk("to_e70_slow", O_SLOW | F);
        end
        step();
        step();
        chk("to_refused", O_SLOW | F);
        mode_req = 1'b0;
        step();
        chk("to_fault_cleared", O_SLOW);
        pll_lock = 1'b1;
        mode_req = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            step();
            if (e == 1)  chk("retry_e1", O_QUP);
            if (e == 66) chk("retry_e66_fast", O_FAST);
        end

        // Lock loss in FAST, mode_req held high
        pll_lock = 1'b0;
        step();
        chk("loss_qdn", O_QDN | F);
        pll_lock = 1'b1;
        step();
        chk("loss_release", O_REL | F);
        step();
        step();
        step();
        chk("loss_release_end", O_REL | F);
        step();
        chk("loss_slow", O_SLOW | F);
        step();
        chk("loss_refused", O_SLOW | F);
        mode_req = 1'b0;
        step();
        chk("loss_cleared", O_SLOW);

        // Abort during quiesce
        core_idle = 1'b0;
        mode_req  = 1'b1;
        step();
        chk("abort_e1", O_QUP);
        step();
        chk("abort_e2", O_QUP);
        step();
        chk("abort_e3", O_QUP);
        mode_req = 1'b0;
        step();
        chk("abort_e4_slow", O_SLOW);
        step();
        chk("abort_e5_slow", O_SLOW);

        // Reset mid LOCK_WAIT at count 20
        core_idle = 1'b1;
        mode_req  = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            step();
            if (e == 22) chk("rst_pre_lw", O_LW);
        end
        reset_n = 1'b0;
        step();
        chk("rst_mid_lw", O_SLOW);
        reset_n = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            step();
            if (e == 1)  chk("rst_retry_e1", O_QUP);
            if (e == 65) chk("rst_retry_e65", O_LW);
            if (e == 66) chk("rst_retry_e66", O_FAST);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
